// File: rtl/pe_mac_q.sv
// Systolic MAC processing element: buffered A/B operands, a two-stage multiply-accumulate
// pipeline, and a scaled, saturated result emitted with a one-cycle strobe.

module pe_mac_q_fifo #(
  parameter int DW = 16,
  parameter int FD = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(FD);

  logic [DW-1:0] mem [FD];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          accept;
  logic          take;

  // A push into a full FIFO is dropped even if a pop frees a slot in the same cycle.
  assign full   = (count == (PW+1)'(FD));
  assign empty  = (count == '0);
  assign accept = push && !full;
  assign take   = pop && !empty;
  assign rdata  = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (take)   rd_ptr <= rd_ptr + PW'(1);
      case ({accept, take})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= wdata;
  end
endmodule

module pe_mac_q #(
  parameter int DW   = 16,
  parameter int FD   = 8,
  parameter int CW   = 8,
  parameter int AW   = 40,
  parameter int FRAC = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  input  logic          awe,
  input  logic          bwe,
  output logic          aff,
  output logic          bff,
  input  logic          start,
  input  logic          acc_keep,
  input  logic [CW-1:0] max_cntr,
  output logic          start_next,
  output logic [DW-1:0] a_out,
  output logic          a_ov,
  output logic [DW-1:0] b_out,
  output logic          b_ov,
  output logic [DW-1:0] s_out,
  output logic          se,
  output logic          sat,
  output logic          busy,
  output logic          ovf
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  drain_last;
  logic [DW-1:0]         a_head;
  logic [DW-1:0]         b_head;
  logic                  a_empty;
  logic                  b_empty;
  logic                  pop;
  logic signed [2*DW-1:0] prod;
  logic                  prod_vld;
  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  r;
  logic                  clip;
  logic [DW-1:0]         r_sat;

  pe_mac_q_fifo #(.DW(DW), .FD(FD)) u_a_fifo (
    .clk(clk), .rst(rst), .push(awe), .wdata(a_in), .pop(pop),
    .rdata(a_head), .full(aff), .empty(a_empty)
  );

  pe_mac_q_fifo #(.DW(DW), .FD(FD)) u_b_fifo (
    .clk(clk), .rst(rst), .push(bwe), .wdata(b_in), .pop(pop),
    .rdata(b_head), .full(bff), .empty(b_empty)
  );

  // Operands are only ever consumed as a pair; a missing side stalls the run.
  assign pop  = (state == RUN) && !a_empty && !b_empty && (cnt != '0);
  assign busy = (state != IDLE);

  // In range iff every bit from the sign position of the DW-bit result upward agrees.
  assign r     = acc >>> FRAC;
  assign clip  = !((&r[AW-1:DW-1]) || !(|r[AW-1:DW-1]));
  assign r_sat = clip ? {r[AW-1], {(DW-1){~r[AW-1]}}} : r[DW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      drain_last <= 1'b0;
      start_next <= 1'b0;
      se         <= 1'b0;
      s_out      <= '0;
      sat        <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      start_next <= start;
      se         <= 1'b0;
      if ((awe && aff) || (bwe && bff) || (start && state != IDLE)) ovf <= 1'b1;
      case (state)
        IDLE: begin
          drain_last <= 1'b0;
          if (start) begin
            cnt   <= max_cntr;
            state <= (max_cntr == '0) ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (pop) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Two cycles let the last product reach the accumulator before it is sampled.
          drain_last <= 1'b1;
          if (drain_last) begin
            state <= DONE;
            se    <= 1'b1;
            s_out <= r_sat;
            sat   <= clip;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_out    <= '0;
      b_out    <= '0;
      a_ov     <= 1'b0;
      b_ov     <= 1'b0;
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else begin
      a_ov     <= pop;
      b_ov     <= pop;
      prod_vld <= pop;
      if (pop) begin
        a_out <= a_head;
        b_out <= b_head;
        prod  <= $signed(a_head) * $signed(b_head);
      end
      // The accumulator survives DONE so a later run can continue the sum.
      if (state == IDLE && start && !acc_keep) acc <= '0;
      else if (prod_vld) acc <= acc + {{(AW-2*DW){prod[2*DW-1]}}, prod};
    end
  end
endmodule

// File: tb/tb_pe_mac_q.sv
// Bench for pe_mac_q: two instances (FRAC=0 and FRAC=15) on shared stimulus, checked every
// cycle against a queue-based transaction model plus literal expectations from hand calculation.

module tb_pe_mac_q;
  localparam int DW = 16;
  localparam int FD = 8;
  localparam int CW = 8;
  localparam int AW = 40;
  localparam longint MAXV = (longint'(1) <<< (DW-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (DW-1));

  typedef logic signed [DW-1:0] word_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] a_in, b_in;
  logic          awe, bwe, start, acc_keep;
  logic [CW-1:0] max_cntr;

  logic          aff_w [2], bff_w [2], sn_w [2], aov_w [2], bov_w [2];
  logic          se_w [2], sat_w [2], busy_w [2], ovf_w [2];
  logic [DW-1:0] aout_w [2], bout_w [2], s_w [2];

  pe_mac_q #(.DW(DW), .FD(FD), .CW(CW), .AW(AW), .FRAC(0)) u0 (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .awe(awe), .bwe(bwe),
    .aff(aff_w[0]), .bff(bff_w[0]), .start(start), .acc_keep(acc_keep), .max_cntr(max_cntr),
    .start_next(sn_w[0]), .a_out(aout_w[0]), .a_ov(aov_w[0]), .b_out(bout_w[0]), .b_ov(bov_w[0]),
    .s_out(s_w[0]), .se(se_w[0]), .sat(sat_w[0]), .busy(busy_w[0]), .ovf(ovf_w[0])
  );

  pe_mac_q #(.DW(DW), .FD(FD), .CW(CW), .AW(AW), .FRAC(15)) u1 (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .awe(awe), .bwe(bwe),
    .aff(aff_w[1]), .bff(bff_w[1]), .start(start), .acc_keep(acc_keep), .max_cntr(max_cntr),
    .start_next(sn_w[1]), .a_out(aout_w[1]), .a_ov(aov_w[1]), .b_out(bout_w[1]), .b_ov(bov_w[1]),
    .s_out(s_w[1]), .se(se_w[1]), .sat(sat_w[1]), .busy(busy_w[1]), .ovf(ovf_w[1])
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  word_t   qa[$], qb[$];
  bit      m_active, armed;
  int      m_rem;
  longint  m_sum, m_done, cyc;
  bit      e_busy, e_sn, e_ov, e_se, e_aff, e_bff, e_ovf;
  logic [DW-1:0] e_a, e_b;
  logic [DW-1:0] e_s [2];
  bit      e_sat [2];

  function automatic void scale(input longint s, input int frac,
                                output logic [DW-1:0] v, output bit st);
    longint r;
    r = s >>> frac;
    if (r > MAXV)      begin v = MAXV[DW-1:0]; st = 1'b1; end
    else if (r < MINV) begin v = MINV[DW-1:0]; st = 1'b1; end
    else               begin v = r[DW-1:0];    st = 1'b0; end
  endfunction

  initial begin
    cyc = 0;
    m_done = -1;
  end

  always @(posedge clk) begin : model
    bit   was_active, fa, fb;
    word_t pa, pb;
    armed = 1'b1;
    if (rst) begin
      qa.delete(); qb.delete();
      m_active = 0; m_rem = 0; m_sum = 0; m_done = -1;
      {e_busy, e_sn, e_ov, e_se, e_aff, e_bff, e_ovf} = '0;
      e_s[0] = '0; e_s[1] = '0; e_sat[0] = 0; e_sat[1] = 0;
    end else begin
      was_active = m_active;
      fa = (qa.size() == FD);
      fb = (qb.size() == FD);
      e_sn = start;
      e_ov = 0;
      e_se = 0;
      if (m_active && m_rem > 0 && qa.size() > 0 && qb.size() > 0) begin
        pa = qa.pop_front();
        pb = qb.pop_front();
        e_a = pa;
        e_b = pb;
        e_ov = 1;
        m_sum += longint'(pa) * longint'(pb);
        m_rem--;
        if (m_rem == 0) m_done = cyc + 3;
      end
      if (was_active && cyc == m_done) m_active = 0;
      if (start && was_active) e_ovf = 1;
      else if (start) begin
        m_active = 1;
        m_rem = int'(max_cntr);
        if (!acc_keep) m_sum = 0;
        if (max_cntr == 0) m_done = cyc + 3;
      end
      if (awe) begin if (fa) e_ovf = 1; else qa.push_back(word_t'(a_in)); end
      if (bwe) begin if (fb) e_ovf = 1; else qb.push_back(word_t'(b_in)); end
      e_aff = (qa.size() == FD);
      e_bff = (qb.size() == FD);
      if (cyc + 1 == m_done) begin
        e_se = 1;
        scale(m_sum, 0,  e_s[0], e_sat[0]);
        scale(m_sum, 15, e_s[1], e_sat[1]);
      end
      e_busy = m_active;
    end
    cyc++;
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("u%0d.busy", i), busy_w[i], e_busy);
        check($sformatf("u%0d.start_next", i), sn_w[i], e_sn);
        check($sformatf("u%0d.a_ov", i), aov_w[i], e_ov);
        check($sformatf("u%0d.b_ov", i), bov_w[i], e_ov);
        check($sformatf("u%0d.se", i), se_w[i], e_se);
        check($sformatf("u%0d.aff", i), aff_w[i], e_aff);
        check($sformatf("u%0d.bff", i), bff_w[i], e_bff);
        check($sformatf("u%0d.ovf", i), ovf_w[i], e_ovf);
        check($sformatf("u%0d.s_out", i), s_w[i], e_s[i]);
        check($sformatf("u%0d.sat", i), sat_w[i], e_sat[i]);
        if (e_ov) begin
          check($sformatf("u%0d.a_out", i), aout_w[i], e_a);
          check($sformatf("u%0d.b_out", i), bout_w[i], e_b);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    k++;
    awe = 0; bwe = 0; start = 0; acc_keep = 0;
  endtask

  task automatic push2(input int a, input int b, input bit wa, input bit wb);
    a_in = a[DW-1:0]; b_in = b[DW-1:0]; awe = wa; bwe = wb;
    step();
  endtask

  task automatic do_start(input int mc, input bit keep);
    start = 1; max_cntr = mc[CW-1:0]; acc_keep = keep; k = 0;
    step();
  endtask

  task automatic wait_se(input string name, input int exp_k,
                         input int s0, input bit st0, input int s1, input bit st1);
    int g = 0;
    while (!se_w[0] && g < 200) begin step(); g++; end
    check({name, ".se_cycle"}, k, exp_k);
    check({name, ".s_out_frac0"}, longint'($signed(s_w[0])), s0);
    check({name, ".sat_frac0"}, sat_w[0], st0);
    check({name, ".s_out_frac15"}, longint'($signed(s_w[1])), s1);
    check({name, ".sat_frac15"}, sat_w[1], st1);
    step();
    check({name, ".busy_after"}, busy_w[0], 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; a_in = '0; b_in = '0; awe = 0; bwe = 0; start = 0; acc_keep = 0; max_cntr = '0;
    repeat (3) @(negedge clk);
    check("reset.busy", busy_w[0], 0);
    check("reset.s_out", s_w[0], 0);
    check("reset.aff", aff_w[0], 0);
    check("reset.ovf", ovf_w[0], 0);
    rst = 0;
    step();

    // Basic dot product with preloaded FIFOs.
    for (int i = 0; i < 4; i++) push2(i + 1, i + 5, 1, 1);
    do_start(4, 0);
    check("basic.start_next", sn_w[0], 1);
    step();
    for (int i = 0; i < 4; i++) begin
      check("basic.a_out", aout_w[0], i + 1);
      check("basic.b_out", bout_w[0], i + 5);
      step();
    end
    wait_se("basic", 7, 70, 0, 0, 0);

    // Streaming from empty FIFOs with one B stall.
    do_start(4, 0);
    step(); step();
    push2(1, 5, 1, 1);
    push2(2, 6, 1, 1);
    push2(3, 0, 1, 0);
    push2(4, 7, 1, 1);
    push2(0, 8, 0, 1);
    wait_se("stall", 11, 70, 0, 0, 0);

    // Saturation, both signs, and fixed-point scaling.
    for (int i = 0; i < 4; i++) push2(32767, 32767, 1, 1);
    do_start(4, 0);
    wait_se("sat_pos", 7, 32767, 1, 32767, 1);
    for (int i = 0; i < 4; i++) push2(-32768, 32767, 1, 1);
    do_start(4, 0);
    wait_se("sat_neg", 7, -32768, 1, -32768, 1);
    for (int i = 0; i < 2; i++) push2(16384, 16384, 1, 1);
    do_start(2, 0);
    wait_se("frac", 5, 32767, 1, 16384, 0);

    // Accumulator continuation.
    push2(1, 5, 1, 1); push2(2, 6, 1, 1);
    do_start(2, 0);
    wait_se("keep1", 5, 17, 0, 0, 0);
    push2(3, 7, 1, 1); push2(4, 8, 1, 1);
    do_start(2, 1);
    wait_se("keep2", 5, 70, 0, 0, 0);
    push2(3, 7, 1, 1); push2(4, 8, 1, 1);
    do_start(2, 0);
    wait_se("keep3", 5, 53, 0, 0, 0);

    // FIFO full, dropped push, start while busy.
    for (int i = 1; i <= 8; i++) push2(i, 0, 1, 0);
    check("full.aff", aff_w[0], 1);
    check("full.ovf_before", ovf_w[0], 0);
    push2(9, 0, 1, 0);
    check("full.ovf_after", ovf_w[0], 1);
    for (int i = 1; i <= 8; i++) push2(0, i, 0, 1);
    check("full.bff", bff_w[0], 1);
    do_start(8, 0);
    check("full.aff_cycle1", aff_w[0], 1);
    step();
    check("full.aff_cycle2", aff_w[0], 0);
    start = 1; max_cntr = 8'd2;
    step();
    check("busy_start.ovf", ovf_w[0], 1);
    wait_se("full", 11, 204, 0, 0, 0);

    // Reset mid-run, then a zero-length run.
    rst = 1; step(); rst = 0;
    for (int i = 0; i < 4; i++) push2(i + 1, i + 5, 1, 1);
    do_start(4, 0);
    step(); step();
    rst = 1; step(); rst = 0;
    check("rst.busy", busy_w[0], 0);
    check("rst.a_ov", aov_w[0], 0);
    check("rst.s_out", s_w[0], 0);
    repeat (6) step();
    do_start(0, 1);
    wait_se("zero", 3, 0, 0, 0, 0);
    do_start(1, 1);
    repeat (5) step();
    check("empty_after_rst.busy", busy_w[0], 1);
    check("empty_after_rst.a_ov", aov_w[0], 0);
    rst = 1; step(); rst = 0; step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pe_mac_q.md
# pe_mac_q

Parametrised systolic processing element: the next generation of the team's 16-bit MAC PE. It has configurable operand width, input FIFO depth, accumulator width and fixed-point output shift. Operands are buffered in per-operand A/B FIFOs, multiplied and accumulated over a run of `max_cntr` terms, then forwarded east/south with valid strobes so neighbours chain without glue logic. The result is scaled, saturated to operand width and emitted with a one-cycle valid. The block tiles into the systolic array exactly like the current PE.

## Interface
Parameters
- `DW`, 16, operand and result width (signed two's complement)
- `FD`, 8, A and B FIFO depth (power of 2, ≥2)
- `CW`, 8, term counter width
- `AW`, 40, accumulator width; must satisfy `AW ≥ 2*DW+CW`
- `FRAC`, 0, arithmetic right shift applied to the accumulator before saturation

Ports
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: reset, synchronous, active-high
- `a_in` in DW: A operand push data
- `b_in` in DW: B operand push data
- `awe` in 1: push `a_in` into the A FIFO
- `bwe` in 1: push `b_in` into the B FIFO
- `aff` out 1: A FIFO full
- `bff` out 1: B FIFO full
- `start` in 1: begin a run; sampled only in IDLE
- `acc_keep` in 1: sampled with `start`; 1 = do not clear the accumulator (continues a previous partial sum)
- `max_cntr` in CW: number of terms in the run, latched at start
- `start_next` out 1: `start` delayed one cycle, for the neighbour PE
- `a_out` out DW / `a_ov` out 1: popped A operand and its valid strobe, to the east neighbour
- `b_out` out DW / `b_ov` out 1: popped B operand and its valid strobe, to the south neighbour
- `s_out` out DW: scaled, saturated result
- `se` out 1: `s_out` valid, 1-cycle pulse
- `sat` out 1: result was clipped; valid with `se`
- `busy` out 1: state is not IDLE
- `ovf` out 1: sticky error flag; set by a push to a full FIFO or by `start` while busy; cleared only by `rst`

## Operation
- FSM states:
  - IDLE → RUN when `start`=1.
  - RUN → DRAIN when the term counter `cnt` reaches 0 (immediately if `max_cntr`=0).
  - DRAIN lasts 2 cycles while the pipeline empties, then → DONE.
  - DONE lasts 1 cycle (asserts `se`), then → IDLE.
- On accepted start:
  - latch `cnt`=`max_cntr`.
  - clear the accumulator unless `acc_keep`=1.
- FIFOs:
  - pushes are accepted in any state, including preload in IDLE.
  - a push while full is dropped and sets `ovf`, even if a pop occurs in the same cycle.
  - data pushed in cycle n is poppable in cycle n+1.
- Pop rule: in RUN, when both FIFOs are non-empty and `cnt`≠0, pop A and B together and decrement `cnt`. If either FIFO is empty, stall; there is no partial pop.
- Pipeline:
  - stage 1: the popped pair is registered to `a_out`/`b_out` with `a_ov`/`b_ov`=1, and the product `p = a*b` (2·DW signed) is registered.
  - stage 2: `acc += sign-extend(p)`, wrapping mod 2^AW. No wrap occurs if the `AW` rule holds.
- Result:
  - `r = acc >>> FRAC`.
  - if `r` exceeds [−2^(DW−1), 2^(DW−1)−1], clip to the bound and set `sat`=1.
  - `s_out` is registered and held until the next DONE.
- The accumulator keeps its value after DONE, which `acc_keep` relies on.
- A `start` while busy is ignored and sets `ovf`.

## Timing
- Reset values:
  - all outputs are 0, including `s_out`, `sat`, `ovf`, `busy`, `start_next`, `a_ov`, `b_ov`.
  - `aff`/`bff` are 0.
  - FIFOs are empty, the accumulator is 0, the FSM is in IDLE.
- Reset mid-run aborts the run immediately and discards FIFO contents; no `se` is produced.
- Cycle numbering: `start` is high in cycle 0.
  - cycle 1: `busy`=1 and `start_next`=1.
  - with preloaded FIFOs and no stalls, pops occur in cycles 1..N (N=`max_cntr`).
  - `a_ov`/`b_ov` are high in cycles 2..N+1.
  - `se`=1 in cycle N+3; `busy` falls in cycle N+4.
- Each stall cycle delays everything after it by one cycle.
- `max_cntr`=0: `se` in cycle 3, `s_out` = saturated current accumulator.
- `aff` is asserted in the cycle after the count reaches `FD`, and deasserts the cycle after a pop from a full FIFO.

## Test plan
- Basic dot product: DW=16, FRAC=0. Preload A=1,2,3,4 and B=5,6,7,8, `max_cntr`=4, start in cycle 0 → `se` in cycle 7 with `s_out`=70, `sat`=0. `a_out` shows 1,2,3,4 in cycles 2–5 and `b_out` shows 5,6,7,8 in the same cycles.
- Streaming with stall: start with the FIFOs empty, push pairs one per cycle beginning cycle 3, but withhold B for one cycle after the second pair → `s_out`=70, with `se` delayed one cycle per stall cycle. The FIFOs are never popped singly.
- Saturation:
  - 4 terms of 32767×32767 → `s_out`=32767, `sat`=1.
  - repeat with A=−32768 → `s_out`=−32768, `sat`=1.
  - FRAC=15 with 2 terms of 16384×16384 → `s_out`=16384, `sat`=0.
- `acc_keep`: run 1,2×5,6 (result 17), then start with `acc_keep`=1 and 3,4×7,8 → `s_out`=70. A third run with `acc_keep`=0 and the same data → 53.
- FIFO full, overflow and busy start: push FD+1 A words → `aff`=1 after FD pushes, last word dropped, `ovf`=1. A `start` while busy is ignored, keeps `ovf`=1, and the current result is unaffected.
- Reset and zero count: assert `rst` in cycle 3 of a 4-term run → all outputs 0 next cycle, no `se`, FIFOs empty. Then `max_cntr`=0 → `se` in cycle 3 with `s_out`=0.
